// File: rtl/sevenseg_decode.sv
// Seven-segment pattern -> binary decoder: snapshots NUM_DIGITS patterns, then folds them MSB-first
// into acc*10 + digit, one digit per clock. Define SEVENSEG_DECODE_BLANK_EN to accept leading blanks (00).
module sevenseg_decode #(
  parameter int NUM_DIGITS = 4,
  parameter int OUT_W      = 14
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  output logic                    busy,
  output logic                    done,
  output logic [OUT_W-1:0]        number,
  output logic [NUM_DIGITS-1:0]   err_mask
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_ACCUM, S_DONE} state_t;

  state_t                      state_q;
  logic [NUM_DIGITS-1:0][6:0]  seg_q;
  logic [IDX_W-1:0]            idx_q;
  logic [OUT_W-1:0]            acc_q, acc_d;
  logic [NUM_DIGITS-1:0]       err_q;
  logic                        lead_q;
  logic                        busy_q, done_q;
  logic [OUT_W-1:0]            number_q;
  logic [NUM_DIGITS-1:0]       err_mask_q;

  logic [6:0] pat;
  logic [3:0] dig_val;
  logic       dig_ok;

  always_comb begin
    pat     = seg_q[idx_q];
    dig_ok  = 1'b1;
    dig_val = 4'd0;
    case (pat)
      7'h3F: dig_val = 4'd0;
      7'h06: dig_val = 4'd1;
      7'h5B: dig_val = 4'd2;
      7'h4F: dig_val = 4'd3;
      7'h66: dig_val = 4'd4;
      7'h6D: dig_val = 4'd5;
      7'h7D: dig_val = 4'd6;
      7'h07: dig_val = 4'd7;
      7'h7F: dig_val = 4'd8;
      7'h67: dig_val = 4'd9;
`ifdef SEVENSEG_DECODE_BLANK_EN
      // Blank is only legal while every digit above it was blank too
      7'h00: dig_ok  = lead_q;
`endif
      default: dig_ok = 1'b0;
    endcase
    acc_d = (acc_q << 3) + (acc_q << 1) + OUT_W'(dig_val);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      seg_q      <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      err_q      <= '0;
      lead_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      number_q   <= '0;
      err_mask_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            seg_q   <= seg_in;
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          busy_q  <= 1'b1;
          acc_q   <= '0;
          err_q   <= '0;
          lead_q  <= 1'b1;
          idx_q   <= IDX_W'(NUM_DIGITS - 1);
          state_q <= S_ACCUM;
        end
        S_ACCUM: begin
          acc_q        <= acc_d;
          err_q[idx_q] <= ~dig_ok;
          lead_q       <= lead_q && (pat == 7'h00);
          idx_q        <= idx_q - 1'b1;
          if (idx_q == '0) state_q <= S_DONE;
        end
        S_DONE: begin
          number_q   <= acc_q;
          err_mask_q <= err_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign number   = number_q;
  assign err_mask = err_mask_q;

endmodule

// File: tb/tb_sevenseg_decode.sv
// Bench for sevenseg_decode: directed cases plus random patterns checked against a table-lookup model.
module tb_sevenseg_decode;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [27:0] seg_in = '0;
  logic        busy, done;
  logic [13:0] number;
  logic [3:0]  err_mask;

  int n_chk = 0;
  int n_fail = 0;

  logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};

  sevenseg_decode #(.NUM_DIGITS(4), .OUT_W(14)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .seg_in(seg_in),
    .busy(busy), .done(done), .number(number), .err_mask(err_mask)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: look each pattern up in the digit table, weight by powers of ten.
  task automatic model(input logic [27:0] s, output int num, output logic [3:0] em);
    int  pw, v;
    bit  lead;
    logic [6:0] p;
    num = 0; em = '0; lead = 1'b1; pw = 1000;
    for (int k = 3; k >= 0; k--) begin
      p = s[7*k +: 7];
      v = -1;
      for (int d = 0; d < 10; d++) if (SEG[d] == p) v = d;
`ifdef SEVENSEG_DECODE_BLANK_EN
      if (p == 7'h00 && lead) v = 0;
`endif
      lead = lead && (p == 7'h00);
      if (v < 0) begin em[k] = 1'b1; v = 0; end
      num += v * pw;
      pw /= 10;
    end
  endtask

  function automatic logic [27:0] pack4(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  // One conversion; noise re-pulses start at T+2/T+4 and scrambles seg_in after the snapshot.
  task automatic conv(input string tag, input logic [27:0] s, input bit noise,
                      input int exp_num, input logic [3:0] exp_err);
    int cyc, nbusy;
    @(negedge clock);
    seg_in = s; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    cyc = 0; nbusy = 0;
    while (cyc < 20) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (busy) nbusy++;
      if (done) break;
      if (noise) begin
        seg_in = 28'($urandom);
        start  = (cyc == 1 || cyc == 3);
      end
    end
    start = 1'b0;
    chk({tag, " latency"}, cyc, 6);
    chk({tag, " busy_cycles"}, nbusy, 5);
    chk({tag, " number"}, number, exp_num);
    chk({tag, " err_mask"}, err_mask, exp_err);
    @(posedge clock);
    @(negedge clock);
    chk({tag, " done_single"}, done, 0);
  endtask

  initial begin
    int          en, cyc;
    logic [3:0]  ee;
    logic [27:0] s;
    logic [6:0]  d [4];
    bit          saw_done;

    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset number", number, 0);
    chk("reset err_mask", err_mask, 0);
    @(negedge clock);
    reset_n = 1'b1;

    conv("t1_1234", pack4(7'h06, 7'h5B, 7'h4F, 7'h66), 1'b0, 1234, 4'b0000);
    conv("t2_9999", pack4(7'h67, 7'h67, 7'h67, 7'h67), 1'b0, 9999, 4'b0000);
    conv("t2_0000", pack4(7'h3F, 7'h3F, 7'h3F, 7'h3F), 1'b0, 0, 4'b0000);
    conv("t3_inv", pack4(7'h06, 7'h5B, 7'h7E, 7'h4F), 1'b0, 1203, 4'b0010);
`ifdef SEVENSEG_DECODE_BLANK_EN
    conv("t4_blank", pack4(7'h00, 7'h3F, 7'h66, 7'h5B), 1'b0, 42, 4'b0000);
    conv("t5_midblank", pack4(7'h06, 7'h00, 7'h5B, 7'h5B), 1'b0, 1022, 4'b0100);
    conv("allblank", 28'h0, 1'b0, 0, 4'b0000);
`else
    conv("t4_blank", pack4(7'h00, 7'h3F, 7'h66, 7'h5B), 1'b0, 42, 4'b1000);
    conv("allblank", 28'h0, 1'b0, 0, 4'b1111);
`endif

    // Reset mid-conversion: assert between edges T+2 and T+3
    @(negedge clock);
    seg_in = pack4(7'h06, 7'h5B, 7'h4F, 7'h66); start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("t6 busy_abort", busy, 0);
    chk("t6 number_abort", number, 0);
    chk("t6 err_abort", err_mask, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
      if (i == 2) reset_n = 1'b1;
    end
    chk("t6 no_done", saw_done, 0);
    conv("t6_restart", pack4(7'h06, 7'h5B, 7'h4F, 7'h66), 1'b0, 1234, 4'b0000);

    conv("t7_noise", pack4(7'h06, 7'h5B, 7'h4F, 7'h66), 1'b1, 1234, 4'b0000);
    // Extra cycle so a queued start (if any) would show as an unexpected busy
    @(negedge clock);
    chk("t7 no_requeue", busy, 0);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 9))
          8:       d[k] = 7'h00;
          9:       d[k] = 7'($urandom_range(0, 127));
          default: d[k] = SEG[$urandom_range(0, 9)];
        endcase
      end
      s = pack4(d[3], d[2], d[1], d[0]);
      model(s, en, ee);
      conv("rand", s, n[0], en, ee);
    end

    // Start held high: back-to-back conversions, one per IDLE visit
    @(negedge clock);
    seg_in = pack4(7'h7F, 7'h07, 7'h7D, 7'h6D); start = 1'b1;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done) cyc++;
    end
    start = 1'b0;
    chk("held_start done_count", cyc, 2);
    chk("held_start number", number, 8765);
    repeat (10) @(negedge clock);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
